// File: rtl/carga_programa_pkg.sv
// Shared definitions for the instruction-memory program loader.
package carga_programa_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } estado_t;

    localparam logic [31:0] HALT_WORD_DEF     = 32'hFFFF_FFFF;
    localparam int          BYTES_POR_PALABRA = 4;

endpackage

// File: rtl/carga_programa_byte_empaquetador.sv
// Packs a UART byte stream into 32-bit words, first byte in the MSB position.
module byte_empaquetador
    import carga_programa_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] palabra,
    output logic        word_ready
);

    localparam logic [1:0] ULTIMO_BYTE = 2'(BYTES_POR_PALABRA - 1);

    logic [1:0] byte_cnt;

    // Pulses in the cycle the fourth byte of a word is strobed in.
    assign word_ready = byte_valid && (byte_cnt == ULTIMO_BYTE);

    // Shift register and mod-4 byte counter; clear only restarts the count,
    // since four fresh bytes fully overwrite the shift register anyway.
    always_ff @(posedge clk) begin
        if (reset) begin
            palabra  <= '0;
            byte_cnt <= '0;
        end else if (clear) begin
            byte_cnt <= '0;
        end else if (byte_valid) begin
            palabra  <= {palabra[23:0], byte_data};
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/carga_programa.sv
// Program loader: fills instruction memory from the UART, then returns the
// memory read port to the CPU fetch stage.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no load yet; memory address follows i_PC, CPU disabled
// ST_RECV  | collecting the four bytes of the next word
// ST_WRITE | single cycle; word written at load_addr
// ST_DONE  | load finished (halt word or memory full); CPU enabled
module carga_programa
    import carga_programa_pkg::*;
#(
    parameter int          NBITS     = 32,
    parameter int          CELDAS    = 60,
    parameter logic [31:0] HALT_WORD = HALT_WORD_DEF
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [7:0]       i_rx_data,
    input  logic             i_rx_valid,
    input  logic [NBITS-1:0] i_PC,
    output logic [NBITS-1:0] o_mem_addr,
    output logic [NBITS-1:0] o_mem_wdata,
    output logic             o_mem_we,
    output logic             o_cpu_enable,
    output logic             o_done,
    output logic             o_error,
    output logic [7:0]       o_word_count
);

    localparam logic [NBITS-1:0] ULTIMA_DIR = NBITS'(CELDAS - BYTES_POR_PALABRA);
    localparam logic [NBITS-1:0] PASO_DIR   = NBITS'(BYTES_POR_PALABRA);

    estado_t          estado;
    logic [NBITS-1:0] load_addr;
    logic [31:0]      palabra;
    logic             word_ready;
    logic             fin_carga;
    logic             acepta_byte;
    logic             arranque;

    // A byte arriving during WRITE starts the next word, unless this write
    // ends the load, in which case it is dropped.
    assign fin_carga   = (estado == ST_WRITE) &&
                         ((palabra == HALT_WORD) || (load_addr == ULTIMA_DIR));
    assign acepta_byte = i_rx_valid &&
                         ((estado == ST_RECV) || ((estado == ST_WRITE) && !fin_carga));
    assign arranque    = i_start && ((estado == ST_IDLE) || (estado == ST_DONE));

    byte_empaquetador u_empaquetador (
        .clk        (i_clk),
        .reset      (i_reset),
        .clear      (arranque),
        .byte_valid (acepta_byte),
        .byte_data  (i_rx_data),
        .palabra    (palabra),
        .word_ready (word_ready)
    );

    assign o_mem_wdata = NBITS'(palabra);

    // Memory port belongs to the fetch stage whenever no load is in progress.
    always_comb begin
        o_mem_addr = load_addr;
        if ((estado == ST_IDLE) || (estado == ST_DONE))
            o_mem_addr = i_PC;
    end

    // Load sequencer with registered write-enable, done, error and CPU enable.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            estado       <= ST_IDLE;
            load_addr    <= '0;
            o_word_count <= '0;
            o_mem_we     <= 1'b0;
            o_cpu_enable <= 1'b0;
            o_done       <= 1'b0;
            o_error      <= 1'b0;
        end else begin
            case (estado)
                ST_IDLE, ST_DONE: begin
                    if (arranque) begin
                        estado       <= ST_RECV;
                        load_addr    <= '0;
                        o_word_count <= '0;
                        o_error      <= 1'b0;
                        o_done       <= 1'b0;
                        o_cpu_enable <= 1'b0;
                    end
                end
                ST_RECV: begin
                    if (word_ready) begin
                        estado   <= ST_WRITE;
                        o_mem_we <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    o_mem_we     <= 1'b0;
                    o_word_count <= o_word_count + 8'd1;
                    if (fin_carga) begin
                        estado       <= ST_DONE;
                        o_done       <= 1'b1;
                        o_cpu_enable <= 1'b1;
                        o_error      <= (palabra != HALT_WORD);
                    end else begin
                        estado    <= ST_RECV;
                        load_addr <= load_addr + PASO_DIR;
                    end
                end
                default: estado <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_carga_programa.sv
module tb_carga_programa;

    localparam int          NBITS     = 32;
    localparam int          CELDAS    = 60;
    localparam int          MAX_WORDS = CELDAS / 4;
    localparam logic [31:0] HALT      = 32'hFFFF_FFFF;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        bit          last;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic [NBITS-1:0] pc;
    logic [NBITS-1:0] mem_addr;
    logic [NBITS-1:0] mem_wdata;
    logic             mem_we;
    logic             cpu_en;
    logic             done;
    logic             error;
    logic [7:0]       word_count;

    int checks = 0;
    int errors = 0;

    exp_t       sb[$];
    logic [7:0] byte_q[$];
    bit         last_pending = 0;

    carga_programa #(.NBITS(NBITS), .CELDAS(CELDAS), .HALT_WORD(HALT)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_start      (start),
        .i_rx_data    (rx_data),
        .i_rx_valid   (rx_valid),
        .i_PC         (pc),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .o_mem_we     (mem_we),
        .o_cpu_enable (cpu_en),
        .o_done       (done),
        .o_error      (error),
        .o_word_count (word_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every memory write is matched against the scoreboard; the write
    // that ends a load must be followed by o_done in the very next cycle.
    always @(negedge clk) begin
        if (last_pending) begin
            check("done_latency", 32'(done), 32'd1);
            last_pending = 0;
        end
        if (rst === 1'b0 && mem_we === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %h data %h with no write expected", mem_addr, mem_wdata);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("write_addr", mem_addr, e.addr);
                check("write_data", mem_wdata, e.data);
                last_pending = e.last;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_valid = 1'b1;
        rx_data  = b;
        step();
        rx_valid = 1'b0;
        rx_data  = $urandom_range(0, 255);
        repeat (gap) step();
    endtask

    task automatic push_word(input logic [31:0] w);
        byte_q.push_back(w[31:24]);
        byte_q.push_back(w[23:16]);
        byte_q.push_back(w[15:8]);
        byte_q.push_back(w[7:0]);
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w == HALT) w = 32'h1234_5678;
        return w;
    endfunction

    // Reference: the byte stream splits into words written at 4*i; the load
    // ends at the first halt word or after MAX_WORDS words, later bytes vanish.
    // gap < 0 selects random gaps of 0..3 idle cycles between strobes.
    task automatic run_load(input int gap);
        int  n_words;
        int  exp_cnt;
        bit  exp_err;
        bit  ended;
        int  waited;
        n_words = byte_q.size() / 4;
        exp_cnt = 0;
        exp_err = 0;
        ended   = 0;
        for (int w = 0; w < n_words && !ended; w++) begin
            exp_t e;
            e.addr = 32'(4 * w);
            e.data = {byte_q[4*w], byte_q[4*w+1], byte_q[4*w+2], byte_q[4*w+3]};
            e.last = (e.data == HALT) || (w == MAX_WORDS - 1);
            sb.push_back(e);
            if (e.last) begin
                ended   = 1;
                exp_err = (e.data != HALT);
                exp_cnt = w + 1;
            end
        end

        pulse_start();
        check("done_drop_after_start", 32'(done), 32'd0);
        check("cpu_drop_after_start", 32'(cpu_en), 32'd0);
        while (byte_q.size() > 0)
            send_byte(byte_q.pop_front(), (gap < 0) ? $urandom_range(0, 3) : gap);

        waited = 0;
        while (done !== 1'b1 && waited < 200) begin
            step();
            waited++;
        end
        repeat (3) step();
        pc = $urandom & 32'hFFFF_FFFC;
        #1;
        check("done", 32'(done), 32'd1);
        check("error", 32'(error), 32'(exp_err));
        check("word_count", 32'(word_count), 32'(exp_cnt));
        check("cpu_enable", 32'(cpu_en), 32'd1);
        check("addr_follows_pc", mem_addr, pc);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        pc       = 32'd8;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Reset / idle values
        check("rst_addr", mem_addr, 32'd8);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_cpu", 32'(cpu_en), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_count", 32'(word_count), 32'd0);
        send_byte(8'h55, 2);
        check("idle_ignores_rx", 32'(mem_we), 32'd0);

        // Two-word program ending in halt, random gaps
        push_word(32'h00E2_3820);
        push_word(HALT);
        run_load(-1);

        // Overflow: fifteen non-halt words fill memory, a sixteenth is ignored
        for (int i = 0; i < MAX_WORDS + 1; i++) push_word(rand_word());
        run_load(-1);

        // Back-to-back strobes, including during the WRITE cycle
        push_word(rand_word());
        push_word(rand_word());
        push_word(rand_word());
        push_word(HALT);
        push_word(rand_word());
        run_load(0);

        // Reset during RECV after two bytes
        pulse_start();
        send_byte(8'h11, 0);
        send_byte(8'h22, 1);
        rst = 1'b1;
        start = 1'b1;
        rx_valid = 1'b1;
        step();
        rst = 1'b0;
        start = 1'b0;
        rx_valid = 1'b0;
        pc = 32'd16;
        #1;
        check("midload_rst_addr", mem_addr, 32'd16);
        check("midload_rst_cpu", 32'(cpu_en), 32'd0);
        check("midload_rst_done", 32'(done), 32'd0);
        check("midload_rst_count", 32'(word_count), 32'd0);
        push_word(32'hAABB_CCDD);
        push_word(HALT);
        run_load(-1);

        // Reload from DONE with a lone halt word
        push_word(HALT);
        run_load(-1);

        // Random programs of random length and halt position
        for (int t = 0; t < 6; t++) begin
            int len;
            len = $urandom_range(1, MAX_WORDS + 2);
            for (int i = 0; i < len; i++)
                push_word((i == len - 1) ? HALT : rand_word());
            run_load((t % 2 == 0) ? -1 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/carga_programa.md
Name: carga_programa

Overview:
Loader and arbiter for the instruction memory. It receives a program as a byte stream from the debug UART receiver, packs the bytes into 32-bit words and writes them at consecutive word addresses (byte address, step 4). It then hands the memory read port back to the CPU fetch stage. It sits between the UART RX, the instruction memory and the PC/pipeline enable.

Parameters:
NBITS, 32, data/address width of the instruction memory
CELDAS, 60, instruction memory size in byte-address cells; the highest valid word address is CELDAS-4
HALT_WORD, 32'hFFFFFFFF, end-of-program marker; it is stored, then loading ends

Ports:
i_clk  input  1  system clock; the only clock
i_reset  input  1  synchronous, active-high reset
i_start  input  1  one-cycle pulse; begins a new program load
i_rx_data  input  8  byte from the UART receiver
i_rx_valid  input  1  one-cycle strobe; i_rx_data is valid
i_PC  input  NBITS  CPU fetch address
o_mem_addr  output  NBITS  address to the instruction memory
o_mem_wdata  output  NBITS  word to write
o_mem_we  output  1  write enable for the instruction memory
o_cpu_enable  output  1  PC and pipeline enable; high only when the program is loaded
o_done  output  1  level; load finished
o_error  output  1  level; memory filled before HALT_WORD arrived
o_word_count  output  8  number of words written in the current load

Behaviour:
- Reset (synchronous, i_reset=1 at a rising edge): state=IDLE, load_addr=0, byte_cnt=0, shift=0, o_word_count=0, o_mem_we=0, o_cpu_enable=0, o_done=0, o_error=0.
- States: IDLE, RECV, WRITE, DONE.
- IDLE:
  - o_mem_addr=i_PC (combinational mux); CPU disabled.
  - i_start -> RECV; clears load_addr, byte_cnt, o_word_count, o_error.
- RECV:
  - Each i_rx_valid does shift={shift[23:0],i_rx_data}. The first byte received is the MSB.
  - byte_cnt increments mod 4. On the 4th byte -> WRITE.
  - Cycles without i_rx_valid hold state; there is no timeout.
  - o_mem_addr=load_addr.
- WRITE (exactly 1 cycle):
  - o_mem_we=1, o_mem_addr=load_addr, o_mem_wdata=shift; o_word_count increments.
  - Next state:
    - if shift==HALT_WORD -> DONE, o_error=0;
    - else if load_addr==CELDAS-4 -> DONE, o_error=1;
    - else load_addr+=4 -> RECV.
  - An i_rx_valid during WRITE is accepted as byte 0 of the next word (byte_cnt=1). It is dropped if the next state is DONE.
- DONE:
  - o_done=1, o_cpu_enable=1, o_mem_addr=i_PC, o_mem_we=0.
  - i_start -> RECV, with the same clears as from IDLE; o_done and o_cpu_enable drop the next cycle.
- o_mem_we is 0 in every state except WRITE. o_mem_wdata reflects shift at all times.
- i_start in RECV or WRITE is ignored. i_rx_valid in IDLE or DONE is ignored.
- Reset mid-load takes priority over all inputs. Words already written stay in memory, and the CPU remains disabled.
- Latency: the write occurs the cycle after the 4th byte strobe. o_done rises the cycle after the HALT write.
- load_addr never exceeds CELDAS-4, so there are no out-of-range writes.

Decomposition:
- Shared package: state encoding constants (IDLE/RECV/WRITE/DONE), HALT_WORD, byte-per-word constant 4.
- One natural sub-module: byte_empaquetador, a 4-byte shift register plus a mod-4 counter with a word_ready pulse.
- The FSM, address counter and fetch/load mux stay in the top module.

Test Plan:
1. Reset then idle: i_PC=8 -> o_mem_addr=8, o_cpu_enable=0, o_done=0, all outputs at reset values.
2. i_start, then bytes 00,E2,38,20, FF,FF,FF,FF with gaps of 0–3 cycles between strobes:
   - write addr 0 data 0x00E23820;
   - write addr 4 data 0xFFFFFFFF;
   - o_done=1 the next cycle, o_word_count=2, o_error=0, o_cpu_enable=1, o_mem_addr follows i_PC.
3. Overflow: send 15 non-halt words:
   - writes at 0,4,…,56;
   - after the write at 56, DONE with o_error=1 and o_word_count=15;
   - a 16th word is ignored and o_mem_we stays 0.
4. Back-to-back: i_rx_valid every cycle, including the WRITE cycle:
   - no byte is lost;
   - the second word is assembled correctly and written at addr 4.
5. Reset during RECV after 2 bytes:
   - IDLE, byte_cnt=0;
   - after a new i_start, 4 bytes AA,BB,CC,DD -> write addr 0 data 0xAABBCCDD.
6. Reload from DONE: i_start then FF,FF,FF,FF:
   - o_done and o_cpu_enable drop 1 cycle after i_start;
   - write addr 0 data 0xFFFFFFFF;
   - o_word_count=1, o_done=1.
